// File: rtl/bloom_filter_store.sv
// Bloom filter storage and query stage.
// Accumulates inserted bloom vectors, answers membership checks through a
// valid/ready response, keeps a saturating insert counter and a serially
// recounted population count that drives the saturated flag.
module bloom_filter_store #(
    parameter int unsigned BL_SIZE    = 16,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned SAT_THRESH = 12,
    parameter int unsigned PC_W       = $clog2(BL_SIZE + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_op,
    input  logic [BL_SIZE-1:0] in_vec,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_hit,
    output logic [BL_SIZE-1:0] filter,
    output logic [CNT_W-1:0]   insert_count,
    output logic [PC_W-1:0]    pop_count,
    output logic               saturated
);

    localparam int unsigned IdxW = (BL_SIZE > 1) ? $clog2(BL_SIZE) : 1;
    localparam logic [IdxW-1:0] IdxLast = IdxW'(BL_SIZE - 1);

    localparam logic [1:0] OpNop    = 2'b00;
    localparam logic [1:0] OpInsert = 2'b01;
    localparam logic [1:0] OpCheck  = 2'b10;
    localparam logic [1:0] OpClear  = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StCount,
        StRsp
    } state_e;

    state_e             state_q, state_d;
    logic [BL_SIZE-1:0] filter_q, filter_d;
    logic [CNT_W-1:0]   icnt_q, icnt_d;
    logic [PC_W-1:0]    pop_q, pop_d;
    logic               sat_q, sat_d;
    logic [IdxW-1:0]    idx_q, idx_d;
    logic [PC_W-1:0]    acc_q, acc_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_hit_q, rsp_hit_d;
    logic [PC_W-1:0]    pc_sum;
    logic               accept;

    assign accept = in_valid && (state_q == StIdle);
    assign pc_sum = acc_q + PC_W'(filter_q[idx_q]);

    // Next-state logic: operation decode in IDLE, serial recount, response hold.
    always_comb begin
        state_d     = state_q;
        filter_d    = filter_q;
        icnt_d      = icnt_q;
        pop_d       = pop_q;
        sat_d       = sat_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        rsp_valid_d = rsp_valid_q;
        rsp_hit_d   = rsp_hit_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    unique case (in_op)
                        OpInsert: begin
                            filter_d = filter_q | in_vec;
                            if (icnt_q != {CNT_W{1'b1}}) begin
                                icnt_d = icnt_q + 1'b1;
                            end
                            idx_d   = '0;
                            acc_d   = '0;
                            state_d = StCount;
                        end
                        OpCheck: begin
                            // Hit only when every requested bit is already present.
                            rsp_hit_d   = (in_vec != '0) && ((in_vec & ~filter_q) == '0);
                            rsp_valid_d = 1'b1;
                            state_d     = StRsp;
                        end
                        OpClear: begin
                            filter_d  = '0;
                            icnt_d    = '0;
                            pop_d     = '0;
                            sat_d     = 1'b0;
                            rsp_hit_d = 1'b0;
                        end
                        OpNop: begin
                            state_d = StIdle;
                        end
                        default: begin
                            state_d = StIdle;
                        end
                    endcase
                end
            end
            StCount: begin
                acc_d = pc_sum;
                idx_d = idx_q + 1'b1;
                if (idx_q == IdxLast) begin
                    // pop_count and saturated stay stale until this final step.
                    pop_d   = pc_sum;
                    sat_d   = (32'(pc_sum) >= SAT_THRESH);
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = StIdle;
                end
            end
            StRsp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; reset discards any partial recount or pending response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            filter_q    <= '0;
            icnt_q      <= '0;
            pop_q       <= '0;
            sat_q       <= 1'b0;
            idx_q       <= '0;
            acc_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            filter_q    <= filter_d;
            icnt_q      <= icnt_d;
            pop_q       <= pop_d;
            sat_q       <= sat_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_hit_q   <= rsp_hit_d;
        end
    end

    assign in_ready     = (state_q == StIdle);
    assign rsp_valid    = rsp_valid_q;
    assign rsp_hit      = rsp_hit_q;
    assign filter       = filter_q;
    assign insert_count = icnt_q;
    assign pop_count    = pop_q;
    assign saturated    = sat_q;

endmodule

// File: tb/tb_bloom_filter_store.sv
// Self-checking bench for bloom_filter_store: directed steps from the test
// plan followed by randomized operations against a behavioural model.
module tb_bloom_filter_store;

    localparam int BL      = 16;
    localparam int CNT_MAX = 255;
    localparam int SAT_TH  = 12;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        rsp_ready = 1'b0;
    logic [1:0]  in_op = 2'b00;
    logic [15:0] in_vec = '0;
    logic        in_ready, rsp_valid, rsp_hit, saturated;
    logic [15:0] filter;
    logic [7:0]  insert_count;
    logic [4:0]  pop_count;

    // Second instance with a 2-bit insert counter.
    logic        v2 = 1'b0;
    logic [1:0]  op2 = 2'b00;
    logic [15:0] vec2 = '0;
    logic        rdy2, rspv2, hit2, sat2;
    logic [15:0] filt2;
    logic [1:0]  ic2;
    logic [4:0]  pc2;

    int errors = 0;
    int checks = 0;

    // Behavioural model state.
    logic [15:0] m_filter = '0;
    int          m_cnt = 0;
    int          m_pop = 0;

    always #5 clk = ~clk;

    bloom_filter_store dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_vec       (in_vec),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_hit      (rsp_hit),
        .filter       (filter),
        .insert_count (insert_count),
        .pop_count    (pop_count),
        .saturated    (saturated)
    );

    bloom_filter_store #(
        .CNT_W (2)
    ) dut2 (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (v2),
        .in_ready     (rdy2),
        .in_op        (op2),
        .in_vec       (vec2),
        .rsp_valid    (rspv2),
        .rsp_ready    (1'b1),
        .rsp_hit      (hit2),
        .filter       (filt2),
        .insert_count (ic2),
        .pop_count    (pc2),
        .saturated    (sat2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".filter"}, 32'(filter), 32'(m_filter));
        chk({tag, ".insert_count"}, 32'(insert_count), 32'(m_cnt));
        chk({tag, ".pop_count"}, 32'(pop_count), 32'(m_pop));
        chk({tag, ".saturated"}, 32'(saturated), (m_pop >= SAT_TH) ? 32'd1 : 32'd0);
    endtask

    task automatic model_reset();
        m_filter = '0;
        m_cnt    = 0;
        m_pop    = 0;
    endtask

    task automatic op_insert(input logic [15:0] vec);
        int old_pop;
        int low;
        old_pop = m_pop;
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 2'b01;
        in_vec   = vec;
        @(posedge clk);
        #1;
        // Keep requesting random ops while busy; they must be ignored.
        in_valid = 1'($urandom);
        in_op    = 2'($urandom);
        in_vec   = 16'($urandom);
        m_filter = m_filter | vec;
        if (m_cnt < CNT_MAX) m_cnt++;
        @(negedge clk);
        chk("ins.filter", 32'(filter), 32'(m_filter));
        chk("ins.insert_count", 32'(insert_count), 32'(m_cnt));
        chk("ins.pop_stale", 32'(pop_count), 32'(old_pop));
        low = in_ready ? 0 : 1;
        for (int i = 0; i < 40 && !in_ready; i++) begin
            @(negedge clk);
            if (!in_ready) low++;
        end
        in_valid = 1'b0;
        m_pop = $countones(m_filter);
        chk("ins.busy_cycles", 32'(low), 32'(BL));
        chk("ins.in_ready", 32'(in_ready), 32'd1);
        chk_model("ins.done");
    endtask

    task automatic op_check(input logic [15:0] vec, input int hold);
        logic exp_hit;
        exp_hit = (vec != 16'h0) && ((vec & ~m_filter) == 16'h0);
        @(negedge clk);
        in_valid  = 1'b1;
        in_op     = 2'b10;
        in_vec    = vec;
        rsp_ready = 1'($urandom);
        @(posedge clk);
        #1;
        in_valid  = (hold > 0);
        in_op     = 2'b01;
        in_vec    = 16'hffff;
        rsp_ready = (hold == 0);
        @(negedge clk);
        chk("chk.rsp_valid", 32'(rsp_valid), 32'd1);
        chk("chk.rsp_hit", 32'(rsp_hit), 32'(exp_hit));
        chk("chk.in_ready_busy", 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold.rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold.rsp_hit", 32'(rsp_hit), 32'(exp_hit));
            chk("hold.in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("chk.rsp_taken", 32'(rsp_valid), 32'd0);
        chk("chk.in_ready_back", 32'(in_ready), 32'd1);
        chk_model("chk.after");
    endtask

    task automatic op_clear();
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 2'b11;
        in_vec   = 16'($urandom);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model_reset();
        @(negedge clk);
        chk_model("clr");
        chk("clr.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("clr.in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic op_nop();
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 2'b00;
        in_vec   = 16'($urandom);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk_model("nop");
        chk("nop.in_ready", 32'(in_ready), 32'd1);
    endtask

    // Global time bound so the run always terminates.
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        int r;
        logic [15:0] v;

        // Reset with inputs toggling.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid  = 1'($urandom);
            in_op     = 2'($urandom);
            in_vec    = 16'($urandom);
            rsp_ready = 1'($urandom);
            v2        = 1'($urandom);
            op2       = 2'($urandom);
            vec2      = 16'($urandom);
        end
        chk("rst.during_filter", 32'(filter), 32'd0);
        in_valid  = 1'b0;
        in_op     = 2'b00;
        rsp_ready = 1'b0;
        v2        = 1'b0;
        reset     = 1'b1;
        #1;
        chk_model("rst");
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd1);

        // Directed sequence from the test plan.
        op_insert(16'h0011);
        op_check(16'h0001, 0);
        op_check(16'h0003, 0);
        op_check(16'h0000, 0);
        op_check(16'h0010, 5);
        op_insert(16'h0fff);
        op_clear();
        op_nop();

        // Back-to-back nop then clear on consecutive edges.
        op_insert(16'h00f0);
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 2'b00;
        @(posedge clk);
        #1;
        in_op = 2'b11;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model_reset();
        @(negedge clk);
        chk_model("b2b");
        chk("b2b.in_ready", 32'(in_ready), 32'd1);

        // Saturating 2-bit counter on the second instance.
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 40 && !rdy2; i++) @(negedge clk);
            @(negedge clk);
            v2   = 1'b1;
            op2  = 2'b01;
            vec2 = 16'h0001;
            @(posedge clk);
            #1;
            v2 = 1'b0;
            @(negedge clk);
        end
        for (int i = 0; i < 40 && !rdy2; i++) @(negedge clk);
        chk("cnt2.ready", 32'(rdy2), 32'd1);
        chk("cnt2.insert_count", 32'(ic2), 32'd3);
        chk("cnt2.pop_count", 32'(pc2), 32'd1);

        // Randomized operations against the model.
        for (int n = 0; n < 50; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0 || r == 9) begin
                op_nop();
            end else if (r <= 3) begin
                v = 16'($urandom) & 16'($urandom) & 16'($urandom);
                op_insert(v);
            end else if (r <= 7) begin
                if ($urandom_range(0, 1) == 1) v = m_filter & 16'($urandom);
                else v = 16'($urandom);
                op_check(v, $urandom_range(0, 3));
            end else begin
                op_clear();
            end
        end

        // Reset in the middle of a recount.
        op_clear();
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 2'b01;
        in_vec   = 16'hffff;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b0;
        #1;
        model_reset();
        chk_model("midrst");
        chk("midrst.rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst.in_ready", 32'(in_ready), 32'd1);
        repeat (20) @(negedge clk);
        chk_model("midrst.no_stale");
        op_check(16'h0001, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bloom_filter_store.md
# bloom_filter_store

Storage and query stage fed by the hash unit's bloom bit-vector output. It accumulates inserted bloom vectors into a filter register and answers membership checks with a valid/ready response. It maintains a saturating insert counter and a serially recomputed population count, which drive a `saturated` flag for the controller. One operation is in flight at a time; the block stalls its input while busy.

## Interface
- `BL_SIZE`, 16: filter width in bits; must equal the hash unit's bloom width.
- `CNT_W`, 8: width of the insert counter.
- `SAT_THRESH`, 12: number of set filter bits at which `saturated` asserts.
- `PC_W`, $clog2(BL_SIZE+1): population-count width (derived).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operation request valid.
- `in_ready`  out  1  block can accept an operation.
- `in_op`  in  2  operation code: 00 nop, 01 insert, 10 check, 11 clear.
- `in_vec`  in  BL_SIZE  bloom vector from the hash unit.
- `rsp_valid`  out  1  check result valid.
- `rsp_ready`  in  1  consumer accepts the check result.
- `rsp_hit`  out  1  check result: 1 = possibly present, 0 = definitely absent.
- `filter`  out  BL_SIZE  current filter contents.
- `insert_count`  out  CNT_W  saturating count of accepted inserts.
- `pop_count`  out  PC_W  number of set bits in `filter`, as of the last completed recount.
- `saturated`  out  1  registered flag, equal to (`pop_count` >= `SAT_THRESH`).

## Operation
- FSM states:
  - IDLE: `in_ready`=1.
  - COUNT: serial recount of set bits after an insert.
  - RSP: holds a check result until the consumer takes it.
- An operation is accepted on any edge where `in_valid` && `in_ready` is true.
- Nop: accepted with no effect; state remains IDLE.
- Insert:
  - `filter` <= `filter` | `in_vec`.
  - `insert_count` increments and saturates at all-ones.
  - Go to COUNT with bit index 0 and accumulator 0.
- COUNT:
  - On each edge, add `filter[idx]` to the accumulator and increment `idx`.
  - On the edge that processes `idx` = BL_SIZE-1, load `pop_count` with the final sum, update `saturated`, and return to IDLE.
  - The recount runs even if `in_vec` adds no new bits.
- Check:
  - `rsp_hit` <= (`in_vec` != 0) && ((`in_vec` & ~`filter`) == 0), evaluated against `filter` at the accept edge.
  - `rsp_valid` <= 1; go to RSP.
  - An all-zero vector always returns `rsp_hit`=0.
- RSP:
  - `rsp_valid` and `rsp_hit` are held stable while `rsp_ready`=0.
  - On the edge with `rsp_ready`=1: `rsp_valid` <= 0, return to IDLE.
- Clear: `filter`, `insert_count`, `pop_count` and `saturated` all go to 0 on the accept edge; state remains IDLE; no recount.
- `in_op` and `in_vec` are sampled only on the accept edge and ignored otherwise.
- `rsp_valid` is never asserted outside RSP.
- Reset (asynchronous, any state, including mid-COUNT or mid-RSP):
  - All outputs go to 0 except `in_ready`, which is 1 after reset deasserts.
  - FSM returns to IDLE; accumulator and index are cleared; any partial recount is discarded.

## Timing
- Insert accepted at edge E0:
  - `filter` and `insert_count` reflect the insert in the cycle after E0.
  - `in_ready`=0 for BL_SIZE cycles (16 by default).
  - `pop_count` and `saturated` update at edge E_BL_SIZE.
  - `in_ready`=1 in the cycle after E_BL_SIZE.
- Check accepted at E0:
  - `rsp_valid`=1 in the cycle after E0 (1-cycle latency).
  - If `rsp_ready` is already high in that cycle, `in_ready` returns to 1 after one more edge.
  - Minimum check throughput: one check per 2 cycles.
- Clear and nop: single cycle; back-to-back acceptance is allowed.
- `saturated` and `pop_count` are stale (old values) during COUNT.

## Test plan
- Reset with all inputs toggling, deassert reset → `filter`=0, `insert_count`=0, `pop_count`=0, `saturated`=0, `rsp_valid`=0, `in_ready`=1.
- Insert 0x0011 → next cycle `filter`=0x0011 and `insert_count`=1; `in_ready` low for exactly 16 cycles; then `pop_count`=2 and `saturated`=0.
- After the 0x0011 insert:
  - Check 0x0001 → `rsp_valid` in the next cycle with `rsp_hit`=1.
  - Check 0x0003 → `rsp_hit`=0.
  - Check 0x0000 → `rsp_hit`=0.
  - Hold `rsp_ready`=0 for 5 cycles → `rsp_valid` and `rsp_hit` stay stable and `in_ready` stays 0.
- Insert 0x0FFF after 0x0011 → `filter`=0x0FFF, `pop_count`=12, `saturated`=1 after the recount; then clear → next cycle all outputs 0 and `in_ready`=1.
- With `CNT_W`=2, perform 5 inserts of 0x0001 → `insert_count`=3 (saturated) and `pop_count`=1.
- Assert reset 7 cycles into a COUNT after inserting 0xFFFF → all outputs 0 immediately; after release, `in_ready`=1, a check of 0x0001 returns `rsp_hit`=0, and no stale `pop_count` load occurs.
